// File: rtl/vga_timing_gen.sv
// 640x480@60 scan counter with registered sync/blank decode and a configurable
// retiming pipeline so hs/vs/blank_d line up with downstream colour latency.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       blank_d,
    output logic       hs,
    output logic       vs,
    output logic       sync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       run_q, run_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    // Stage 0 of each pipe is the undelayed registered decode; stage N is N clocks later.
    logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;
    logic [SYNC_DELAY:0] blk_pipe_q, blk_pipe_d;

    always_comb begin
        run_d = 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        // First edge after reset only arms the counters so (0,0) gets a full cycle.
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        ls_d = (x_d == 10'd0);
        fs_d = (x_d == 10'd0) && (y_d == 10'd0);

        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        blk_pipe_d    = blk_pipe_q;
        hs_pipe_d[0]  = !((x_d >= HS_BEG) && (x_d < HS_END));
        vs_pipe_d[0]  = !((y_d >= VS_BEG) && (y_d < VS_END));
        blk_pipe_d[0] = (x_d < H_VIS) && (y_d < V_VIS);
        for (int i = 1; i <= SYNC_DELAY; i++) begin
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
            blk_pipe_d[i] = blk_pipe_q[i-1];
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            ls_q       <= 1'b0;
            fs_q       <= 1'b0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            blk_pipe_q <= '0;
        end else begin
            run_q      <= run_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ls_q       <= ls_d;
            fs_q       <= fs_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            blk_pipe_q <= blk_pipe_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blk_pipe_q[0];
    assign blank_d     = blk_pipe_q[SYNC_DELAY];
    assign hs          = hs_pipe_q[SYNC_DELAY];
    assign vs          = vs_pipe_q[SYNC_DELAY];
    assign sync        = 1'b0;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
